// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction path: loader state encodings,
// byte width and the default instruction/address widths, so the fetch unit
// and the loader agree on the imem geometry.
package imem_loader_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_INSTR_W = 16;
    localparam int DEFAULT_ADDR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    // A program longer than the memory cannot be loaded; only possible when
    // the memory holds fewer than 256 words.
    function automatic logic count_too_big(logic [BYTE_W-1:0] n, int depth);
        return int'(n) > depth;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the program loader. The loader
// connects through the master modport; the byte source and imem model use
// the slave modport.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) ();

    logic                in_valid;
    logic [BYTE_W-1:0]   in_data;
    logic                in_ready;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Program loader: receives count byte, N instructions (MSB first) and an XOR
// checksum byte, writes each instruction into imem, and releases the core
// from reset only when the checksum matches. INSTR_W must be a multiple of 8.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int BPI    = INSTR_W / BYTE_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BCNT_W = (BPI > 1) ? $clog2(BPI) : 1;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   n_q, n_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [INSTR_W-1:0]  word_q, word_d;

    logic                in_ready_s;
    logic                accept;

    assign accept = bus.in_valid && in_ready_s;

    // State and datapath registers; reset leaves imem contents untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
        end
    end

    // Next state plus byte assembly, checksum and address counting.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    n_d    = bus.in_data;
                    csum_d = bus.in_data;
                    idx_d  = '0;
                    bcnt_d = '0;
                    if (bus.in_data == '0)
                        state_d = ST_CHECK;
                    else if (count_too_big(bus.in_data, DEPTH))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    word_d = INSTR_W'({word_q, bus.in_data});
                    csum_d = csum_q ^ bus.in_data;
                    if (bcnt_q == BCNT_W'(BPI - 1)) begin
                        bcnt_d  = '0;
                        state_d = ST_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                // The last index is held rather than advanced so the counter
                // never wraps, even for a full-depth program.
                if (int'(idx_q) == int'(n_q) - 1) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept)
                    state_d = (bus.in_data == csum_q) ? ST_RUN : ST_ERR;
            end
            ST_RUN, ST_ERR: begin
                if (start) state_d = ST_LEN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are pure state decode or register values, never input-driven.
    always_comb begin
        in_ready_s     = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                         (state_q == ST_CHECK);
        busy           = in_ready_s || (state_q == ST_WRITE);
        done           = (state_q == ST_RUN);
        error          = (state_q == ST_ERR);
        cpu_reset      = (state_q != ST_RUN);
        bus.in_ready   = in_ready_s;
        bus.imem_we    = (state_q == ST_WRITE);
        bus.imem_addr  = idx_q;
        bus.imem_wdata = word_q;
    end

endmodule
